// File: rtl/fft_spi_in.sv
`default_nettype none
// ============================================================================
// Module   : fft_spi_in
// Function : SPI mode-0 slave that assembles 2*N bytes into one FFT input frame.
//            Optional HOLD timeout enabled by defining FFT_SPI_IN_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module fft_spi_in #(
  parameter int N       = 32,
  parameter int MSB     = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   i_Rst_L,
  input  logic                   sclk,
  input  logic                   mosi,
  input  logic                   cs,
  output logic [N*MSB-1:0]       data_bus,
  output logic                   frame_valid,
  output logic [$clog2(2*N):0]   byte_count,
  output logic                   busy,
  output logic                   frame_err
);

  localparam int c_BYTE_W = MSB / 2;
  localparam int c_BYTES  = 2 * N;
  localparam int c_BIT_W  = (c_BYTE_W > 1) ? $clog2(c_BYTE_W) : 1;
  localparam int c_CNT_W  = $clog2(2 * N) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_sclk_meta, r_sclk_sync, r_sclk_d;
  logic                  r_mosi_meta, r_mosi_sync;
  logic                  r_cs_meta, r_cs_sync;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic [c_BYTE_W-1:0]   r_shift;
  logic [c_BYTE_W-1:0]   r_byte_data;
  logic                  r_byte_ready;
  logic [N*MSB-1:0]      r_shadow;

  logic                  w_sclk_rise, w_cs_fall, w_cs_active, w_last, w_timeout;
  logic [c_BIT_W-1:0]    w_bit_base;
  logic [c_CNT_W-1:0]    w_cnt_next, w_cnt_final;
  logic [N*MSB-1:0]      w_shadow_next;

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
    end else begin
      r_sclk_meta <= sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_d    <= r_sclk_sync;
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
      r_cs_meta   <= cs;
      r_cs_sync   <= r_cs_meta;
    end
  end

  // SHIFT means cs was low last cycle, so a final sclk edge seen together
  // with the cs rise is still accepted.
  assign w_sclk_rise = r_sclk_sync & ~r_sclk_d;
  assign w_cs_fall   = ~r_cs_sync & (r_state != SHIFT);
  assign w_cs_active = ~r_cs_sync | (r_state == SHIFT);
  assign w_bit_base  = w_cs_fall ? '0 : r_bit_cnt;

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_data  <= '0;
      r_byte_ready <= 1'b0;
    end else begin
      r_byte_ready <= 1'b0;
      if (w_sclk_rise && w_cs_active) begin
        r_shift <= {r_shift[c_BYTE_W-2:0], r_mosi_sync};
        if (w_bit_base == c_BIT_W'(c_BYTE_W - 1)) begin
          r_bit_cnt    <= '0;
          r_byte_data  <= {r_shift[c_BYTE_W-2:0], r_mosi_sync};
          r_byte_ready <= 1'b1;
        end else begin
          r_bit_cnt <= w_bit_base + 1'b1;
        end
      end else begin
        r_bit_cnt <= w_bit_base;
      end
    end
  end

  always_comb begin
    w_shadow_next = r_shadow;
    for (int k = 0; k < c_BYTES; k++) begin
      if (r_byte_ready && (int'(byte_count) == k))
        w_shadow_next[k*c_BYTE_W +: c_BYTE_W] = r_byte_data;
    end
  end

  assign w_last     = r_byte_ready && (byte_count == c_CNT_W'(c_BYTES - 1));
  assign w_cnt_next = !r_byte_ready ? byte_count :
                      (w_last ? '0 : byte_count + 1'b1);

`ifdef FFT_SPI_IN_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT + 1);
  logic [c_TO_W-1:0] r_hold_cnt;

  assign w_timeout = (r_state == HOLD) && r_cs_sync && !r_byte_ready &&
                     (r_hold_cnt == c_TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_hold_cnt <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= w_timeout;
      if ((r_state == HOLD) && r_cs_sync && !w_timeout)
        r_hold_cnt <= r_hold_cnt + 1'b1;
      else
        r_hold_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign frame_err = 1'b0;
`endif

  assign w_cnt_final = w_timeout ? '0 : w_cnt_next;

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      data_bus    <= '0;
      frame_valid <= 1'b0;
      byte_count  <= '0;
      busy        <= 1'b0;
    end else begin
      r_shadow    <= w_shadow_next;
      frame_valid <= w_last;
      byte_count  <= w_cnt_final;
      busy        <= (w_cnt_final != '0) || !r_cs_sync;
      if (w_last)
        data_bus <= w_shadow_next;
      case (r_state)
        IDLE: begin
          if (!r_cs_sync)                r_state <= SHIFT;
          else if (w_cnt_final != '0)    r_state <= HOLD;
        end
        SHIFT: begin
          if (r_cs_sync)
            r_state <= (w_cnt_final != '0) ? HOLD : IDLE;
        end
        HOLD: begin
          if (!r_cs_sync)                r_state <= SHIFT;
          else if (w_cnt_final == '0)    r_state <= IDLE;
        end
        default:                         r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_spi_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_spi_in
// Function : Directed scoreboard bench for fft_spi_in (N=32, MSB=16).
// Revision : 1.0
// ============================================================================
module tb_fft_spi_in;

  localparam int N       = 32;
  localparam int MSB     = 16;
  localparam int TIMEOUT = 1024;
  localparam int W       = N * MSB;
  localparam int BYTES   = 2 * N;

  logic                 clk = 1'b0;
  logic                 i_Rst_L = 1'b0;
  logic                 sclk = 1'b0;
  logic                 mosi = 1'b0;
  logic                 cs = 1'b1;
  logic [W-1:0]         data_bus;
  logic                 frame_valid;
  logic [$clog2(2*N):0] byte_count;
  logic                 busy;
  logic                 frame_err;

  int          n_tests = 0;
  int          n_fail = 0;
  int          fv_count = 0;
  int          err_count = 0;
  int          fv_before;
  int unsigned cyc = 0;
  int unsigned last_rise_cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_shadow = '0;
  logic [W-1:0] exp_bus = '0;
  int           m_cnt = 0;

  fft_spi_in #(.N(N), .MSB(MSB), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .i_Rst_L     (i_Rst_L),
    .sclk        (sclk),
    .mosi        (mosi),
    .cs          (cs),
    .data_bus    (data_bus),
    .frame_valid (frame_valid),
    .byte_count  (byte_count),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every frame_valid pops the frame the stimulus predicted.
  always @(negedge clk) begin
    if (i_Rst_L && frame_valid) begin
      fv_count++;
      if (exp_q.size() == 0)
        check_i("unexpected_frame_valid", 1, 0);
      else begin
        check("frame_data", data_bus, exp_q.pop_front());
        check_i("fv_latency", int'(cyc - last_rise_cyc), 4);
      end
    end
    if (i_Rst_L && frame_err) err_count++;
  end

  // quick raises cs together with the final sclk edge
  task automatic send_byte(input logic [7:0] b, input int nbits = 8, input bit quick = 1'b0);
    if (nbits == 8) begin
      m_shadow[m_cnt*8 +: 8] = b;
      if (m_cnt == BYTES - 1) begin
        exp_q.push_back(m_shadow);
        exp_bus = m_shadow;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    @(negedge clk); cs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      last_rise_cyc = cyc;
      if (quick && i == 0) cs = 1'b1;
      repeat (2) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); i_Rst_L = 1'b0;
    repeat (2) @(negedge clk);
    i_Rst_L = 1'b1;
    m_cnt = 0;
    m_shadow = '0;
    exp_bus = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat;

    repeat (3) @(negedge clk);
    check("rst_data_bus", data_bus, '0);
    check_i("rst_frame_valid", int'(frame_valid), 0);
    check_i("rst_byte_count", int'(byte_count), 0);
    check_i("rst_busy", int'(busy), 0);
    check_i("rst_frame_err", int'(frame_err), 0);
    i_Rst_L = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp frame 0x00..0x3F, one byte per cs
    for (int k = 0; k < BYTES; k++) begin
      send_byte(8'(k), 8, k == 20);
      if (k == 9) begin
        check_i("partial_count", int'(byte_count), 10);
        check("partial_hidden", data_bus, '0);
        check_i("busy_in_hold", int'(busy), 1);
      end
    end
    repeat (4) @(negedge clk);
    check_i("ramp_fv_count", fv_count, 1);
    check_i("ramp_byte0", int'(data_bus[7:0]), 8'h00);
    check_i("ramp_byte63", int'(data_bus[511:504]), 8'h3F);
    check_i("ramp_count_wrap", int'(byte_count), 0);
    check_i("ramp_busy_idle", int'(busy), 0);

    // Back-to-back frames
    for (int k = 0; k < BYTES; k++) send_byte(8'hAA);
    pat = {64{8'hAA}};
    check("b2b_first", data_bus, pat);
    check_i("b2b_fv_count1", fv_count, 2);
    for (int k = 0; k < BYTES; k++) send_byte(8'h55);
    pat = {64{8'h55}};
    check("b2b_second", data_bus, pat);
    check_i("b2b_fv_count2", fv_count, 3);

    // Aborted byte 3, resent as 0xC3
    for (int k = 0; k < 3; k++) send_byte(8'(8'h10 + k));
    send_byte(8'hFF, 5);
    check_i("abort_count_kept", int'(byte_count), 3);
    send_byte(8'hC3);
    for (int k = 4; k < BYTES; k++) send_byte(8'(k), 8, k == BYTES - 1);
    repeat (4) @(negedge clk);
    check_i("abort_slot3", int'(data_bus[31:24]), 8'hC3);
    check_i("abort_fv_count", fv_count, 4);

    // Reset mid-frame
    for (int k = 0; k < 10; k++) send_byte(8'h77);
    pulse_reset();
    check_i("midrst_count", int'(byte_count), 0);
    check("midrst_data_bus", data_bus, '0);
    fv_before = fv_count;
    for (int k = 0; k < BYTES; k++) send_byte(8'(8'h80 + k));
    repeat (4) @(negedge clk);
    check_i("midrst_one_pulse", fv_count, fv_before + 1);
    check_i("midrst_byte0", int'(data_bus[7:0]), 8'h80);

    // Long cs-high gap in HOLD
    for (int k = 0; k < 10; k++) send_byte(8'h3C);
    repeat (1100) @(negedge clk);
`ifdef FFT_SPI_IN_TIMEOUT_EN
    check_i("timeout_count", int'(byte_count), 0);
    check_i("timeout_err_pulses", err_count, 1);
    check("timeout_data_bus", data_bus, exp_bus);
    m_cnt = 0;
`else
    check_i("hold_count", int'(byte_count), 10);
    check_i("hold_no_err", err_count, 0);
    check("hold_data_bus", data_bus, exp_bus);
    pulse_reset();
`endif

    // 0xA5 frame at sclk = clk/4
    fv_before = fv_count;
    for (int k = 0; k < BYTES; k++) send_byte(8'hA5);
    repeat (4) @(negedge clk);
    pat = {64{8'hA5}};
    check("a5_frame", data_bus, pat);
    check_i("a5_fv_count", fv_count, fv_before + 1);

    check_i("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_spi_in.md
FFT_SPI_IN -- requirements
Module: fft_spi_in

Interface
REQ-001 The block SHALL have parameter N, default 32: number of complex FFT points per frame.
REQ-002 The block SHALL have parameter MSB, default 16: bits per point word; each byte is MSB/2 bits wide, and a frame is 2*N bytes.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024: clk cycles of cs high that abort a partial frame, used only when FFT_SPI_IN_TIMEOUT_EN is defined.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port sclk, input, 1 bit: SPI clock from the remote master, asynchronous to clk.
REQ-007 The block SHALL have port mosi, input, 1 bit: SPI serial data, asynchronous to clk.
REQ-008 The block SHALL have port cs, input, 1 bit: SPI chip select, active-low, asynchronous to clk.
REQ-009 The block SHALL have port data_bus, output, N*MSB bits: the last complete frame; byte k occupies bits [(k+1)*MSB/2-1 : k*MSB/2].
REQ-010 The block SHALL have port frame_valid, output, 1 bit: a one-cycle pulse on frame completion.
REQ-011 The block SHALL have port byte_count, output, $clog2(2*N)+1 bits: the number of bytes received in the current partial frame.
REQ-012 The block SHALL have port busy, output, 1 bit: high while byte_count is nonzero or cs is low.
REQ-013 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse when a partial frame is aborted by timeout.

Function
REQ-014 The block SHALL pass sclk, mosi and cs each through a two-flop synchronizer clocked by clk before any use; clk SHALL be at least 4x the sclk frequency.
REQ-015 The block SHALL use SPI mode 0: mosi sampled on the synchronized sclk rising edge, MSB of each byte first.
REQ-016 The block SHALL implement the states IDLE, SHIFT and HOLD: IDLE = cs high and byte_count 0; SHIFT = cs low; HOLD = cs high and byte_count nonzero.
REQ-017 The block SHALL make these transitions: IDLE->SHIFT and HOLD->SHIFT on synchronized cs low; SHIFT->HOLD or SHIFT->IDLE on synchronized cs high, according to byte_count.
REQ-018 The block SHALL ignore sclk edges while synchronized cs is high.
REQ-019 The block SHALL reset the bit counter to 0 on every cs falling edge.
REQ-020 On the (MSB/2)th sampled bit, the block SHALL write the assembled byte into shadow slot byte_count on the next clk edge and then increment byte_count.
REQ-021 The block SHALL keep byte_count across cs deassertions, so that one frame may span many cs assertions (for example one byte per cs).
REQ-022 When byte 2*N-1 is written, the block SHALL, on the same clk edge, copy the full shadow into data_bus, assert frame_valid for exactly 1 cycle and wrap byte_count to 0.
REQ-023 The block SHALL change data_bus only at frame completion; a partial frame SHALL never be visible on data_bus.
REQ-024 When cs rises mid-byte, the block SHALL discard the partial bits and leave byte_count unchanged.
REQ-025 Latency from the sclk edge carrying the last bit of a frame to frame_valid high SHALL be 4 clk cycles: 2 synchronizer cycles, 1 edge-detect cycle and 1 write cycle.
REQ-026 When a cs rising edge and the final bit's sclk edge are detected in the same cycle, the block SHALL accept the byte and then process the cs deassertion.
REQ-027 The block SHALL accept back-to-back frames with no idle gap; the first byte of the next frame goes to slot 0.

Reset
REQ-028 While i_Rst_L is low, the block SHALL asynchronously force data_bus=0, shadow=0, frame_valid=0, frame_err=0, byte_count=0, busy=0, bit counter=0, state=IDLE and synchronizers to idle (cs=1, sclk=0).
REQ-029 After a reset asserted mid-frame, the next received byte SHALL be written to slot 0.

Configuration
REQ-030 With FFT_SPI_IN_TIMEOUT_EN defined, a counter SHALL run while in HOLD, and after TIMEOUT consecutive HOLD cycles the block SHALL clear byte_count to 0, pulse frame_err for 1 cycle and go to IDLE.
REQ-031 With FFT_SPI_IN_TIMEOUT_EN defined, the HOLD counter SHALL clear on any cs low; data_bus SHALL be unchanged on a timeout.
REQ-032 Without FFT_SPI_IN_TIMEOUT_EN, frame_err SHALL be tied to 0, no timeout counter SHALL exist, and HOLD SHALL persist indefinitely.

Verification
REQ-033 Reset, then 64 bytes 0x00..0x3F, one byte per cs, with N=32 and MSB=16 -> one frame_valid pulse, data_bus[7:0]=0x00, data_bus[511:504]=0x3F, byte_count=0.
REQ-034 Two back-to-back frames (0xAA x64, then 0x55 x64) -> two frame_valid pulses; data_bus is all 0xAA between the pulses and all 0x55 after the second.
REQ-035 cs rises after 5 bits of byte 3, then byte 3 is resent as 0xC3 -> slot 3 holds 0xC3 and the frame completes after 64 full bytes.
REQ-036 i_Rst_L pulsed low after 10 bytes, then 64 bytes sent -> exactly one frame_valid pulse, at the 64th byte after reset.
REQ-037 With FFT_SPI_IN_TIMEOUT_EN and TIMEOUT=1024: 10 bytes, then cs held high for 1100 cycles -> frame_err pulses, byte_count=0, data_bus unchanged; without the macro -> byte_count stays 10.
REQ-038 A frame with sclk at clk/4 and mosi toggling each bit (0xA5 per byte) -> all bytes equal 0xA5, and frame_valid rises 4 cycles after the last sclk rising edge.
